tagged_branch_buffer: RTL and testbench

- Parametrised, tagged branch target buffer with per-entry history-selected saturating counters.
- Fetch stage reads a direction prediction and a target combinationally from pc_f_i.
- Execute stage allocates, corrects and trains entries from the resolved branch outcome.
- Adds tags, valid bits, a flush and configurable counter width.

---
 rtl/tagged_branch_buffer_pkg.sv | 36 +++
 rtl/tagged_branch_buffer_entry_update.sv | 51 +++++
 rtl/tagged_branch_buffer.sv | 150 +++++++++++++++
 tb/tb_tagged_branch_buffer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tagged_branch_buffer_pkg.sv
// Shared definitions for the tagged branch target buffer: branch-op encoding,
// PC type, counter initialisation constants and the saturating counter step.
package tagged_branch_buffer_pkg;

  typedef enum logic [1:0] {
    NON_BRANCH = 2'b00,
    BR_COND    = 2'b01,
    BR_JAL     = 2'b10,
    BR_JALR    = 2'b11
  } branch_op_t;

  typedef logic [31:0] pc_t;

  // Weakly-not-taken: largest value whose MSB is clear.
  function automatic int unsigned weak_nt_f(input int unsigned ctr_w);
    return (32'd1 << (ctr_w - 1)) - 32'd1;
  endfunction

  // Weakly-taken: smallest value whose MSB is set.
  function automatic int unsigned weak_t_f(input int unsigned ctr_w);
    return 32'd1 << (ctr_w - 1);
  endfunction

  function automatic int unsigned ctr_max_f(input int unsigned ctr_w);
    return (32'd1 << ctr_w) - 32'd1;
  endfunction

  // One saturating step towards the resolved outcome.
  function automatic int unsigned sat_update(input int unsigned ctr,
                                             input logic        taken,
                                             input int unsigned max);
    if (taken) return (ctr >= max) ? max : ctr + 32'd1;
    else       return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
  endfunction

endpackage

// File: rtl/tagged_branch_buffer_entry_update.sv
// btb_entry_update: next {valid, tag, target, counters} of the entry addressed
// by the execute stage. Purely combinational; the caller decides whether the
// result is written (update active, no flush).
module btb_entry_update
  import tagged_branch_buffer_pkg::*;
#(
  parameter int TAG_W  = 8,
  parameter int HIST_W = 2,
  parameter int CTR_W  = 2
) (
  input  logic                                cur_valid_i,
  input  logic [TAG_W-1:0]                    cur_tag_i,
  input  logic [31:0]                         cur_target_i,
  input  logic [(2**HIST_W)-1:0][CTR_W-1:0]   cur_ctrs_i,
  input  logic [TAG_W-1:0]                    tag_e_i,
  input  logic [HIST_W-1:0]                   hist_e_i,
  input  logic                                taken_i,
  input  logic                                target_match_i,
  input  logic [31:0]                         target_e_i,
  output logic                                nxt_valid_o,
  output logic [TAG_W-1:0]                    nxt_tag_o,
  output logic [31:0]                         nxt_target_o,
  output logic [(2**HIST_W)-1:0][CTR_W-1:0]   nxt_ctrs_o
);

  localparam int NCTR = 2**HIST_W;
  localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'(weak_nt_f(CTR_W));
  localparam logic [CTR_W-1:0] WEAK_T  = CTR_W'(weak_t_f(CTR_W));
  localparam int unsigned      CTR_MAX = ctr_max_f(CTR_W);

  logic             e_hit;
  logic [CTR_W-1:0] sel_ctr;

  // Train on a tag hit with a correct target, otherwise (re)allocate.
  always_comb begin
    e_hit        = cur_valid_i && (cur_tag_i == tag_e_i);
    sel_ctr      = cur_ctrs_i[hist_e_i];
    nxt_valid_o  = 1'b1;
    nxt_tag_o    = tag_e_i;
    nxt_target_o = target_e_i;
    nxt_ctrs_o   = cur_ctrs_i;
    if (e_hit && target_match_i) begin
      nxt_target_o         = cur_target_i;
      nxt_ctrs_o[hist_e_i] = CTR_W'(sat_update(32'(sel_ctr), taken_i, CTR_MAX));
    end else begin
      nxt_ctrs_o           = {NCTR{WEAK_NT}};
      nxt_ctrs_o[hist_e_i] = taken_i ? WEAK_T : WEAK_NT;
    end
  end

endmodule

// File: rtl/tagged_branch_buffer.sv
// Direct-mapped, tagged branch target buffer with history-selected saturating
// counters. Fetch lookup is combinational; execute updates one entry per edge.
// Optional macro TAGGED_BTB_FWD_EN: a fetch that matches this cycle's update
// (same index and tag) sees the values being written instead of stored state.
module tagged_branch_buffer
  import tagged_branch_buffer_pkg::*;
#(
  parameter int ENTRIES = 256,
  parameter int TAG_W   = 8,
  parameter int HIST_W  = 2,
  parameter int CTR_W   = 2
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              flush_i,
  input  logic [31:0]       pc_f_i,
  input  logic [HIST_W-1:0] hist_f_i,
  input  logic [31:0]       pc_e_i,
  input  logic [HIST_W-1:0] hist_e_i,
  input  logic [1:0]        branch_op_e_i,
  input  logic              pc_src_res_e_i,
  input  logic              target_match_i,
  input  logic [31:0]       pc_target_e_i,
  output logic              hit_f_o,
  output logic              pc_src_pred_f_o,
  output logic [31:0]       pred_pc_target_f_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int NCTR  = 2**HIST_W;
  localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'(weak_nt_f(CTR_W));

  typedef logic [IDX_W-1:0]            idx_t;
  typedef logic [TAG_W-1:0]            tag_t;
  typedef logic [NCTR-1:0][CTR_W-1:0]  ctrs_t;

  logic  valid_q  [ENTRIES];
  logic  valid_d  [ENTRIES];
  tag_t  tag_q    [ENTRIES];
  tag_t  tag_d    [ENTRIES];
  pc_t   target_q [ENTRIES];
  pc_t   target_d [ENTRIES];
  ctrs_t ctrs_q   [ENTRIES];
  ctrs_t ctrs_d   [ENTRIES];

  idx_t  idx_f, idx_e;
  tag_t  tag_f, tag_e;
  logic  upd_active;

  logic  nxt_valid;
  tag_t  nxt_tag;
  pc_t   nxt_target;
  ctrs_t nxt_ctrs;

  logic  lk_valid;
  tag_t  lk_tag;
  pc_t   lk_target;
  ctrs_t lk_ctrs;

  logic  unused_pc_bits;

  assign idx_f = pc_f_i[IDX_W+1:2];
  assign tag_f = pc_f_i[IDX_W+TAG_W+1:IDX_W+2];
  assign idx_e = pc_e_i[IDX_W+1:2];
  assign tag_e = pc_e_i[IDX_W+TAG_W+1:IDX_W+2];

  // Byte offset and PC bits above the tag never take part in the lookup.
  assign unused_pc_bits = ^{pc_f_i[1:0], pc_f_i[31:IDX_W+TAG_W+2],
                            pc_e_i[1:0], pc_e_i[31:IDX_W+TAG_W+2]};

  // A flush in the same cycle drops the update.
  assign upd_active = (branch_op_e_i != NON_BRANCH) && !flush_i;

  btb_entry_update #(
    .TAG_W  (TAG_W),
    .HIST_W (HIST_W),
    .CTR_W  (CTR_W)
  ) u_entry_update (
    .cur_valid_i    (valid_q[idx_e]),
    .cur_tag_i      (tag_q[idx_e]),
    .cur_target_i   (target_q[idx_e]),
    .cur_ctrs_i     (ctrs_q[idx_e]),
    .tag_e_i        (tag_e),
    .hist_e_i       (hist_e_i),
    .taken_i        (pc_src_res_e_i),
    .target_match_i (target_match_i),
    .target_e_i     (pc_target_e_i),
    .nxt_valid_o    (nxt_valid),
    .nxt_tag_o      (nxt_tag),
    .nxt_target_o   (nxt_target),
    .nxt_ctrs_o     (nxt_ctrs)
  );

  // Next state: flush clears every valid bit, otherwise only entry idx_e moves.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_d[i]  = valid_q[i];
      tag_d[i]    = tag_q[i];
      target_d[i] = target_q[i];
      ctrs_d[i]   = ctrs_q[i];
    end
    if (flush_i) begin
      for (int i = 0; i < ENTRIES; i++) valid_d[i] = 1'b0;
    end else if (upd_active) begin
      valid_d[idx_e]  = nxt_valid;
      tag_d[idx_e]    = nxt_tag;
      target_d[idx_e] = nxt_target;
      ctrs_d[idx_e]   = nxt_ctrs;
    end
  end

  // Entry storage; reset empties the table and parks counters at weakly-not-taken.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctrs_q[i]   <= {NCTR{WEAK_NT}};
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= valid_d[i];
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctrs_q[i]   <= ctrs_d[i];
      end
    end
  end

  // Fetch lookup: stored entry, optionally bypassed by the in-flight write.
  always_comb begin
    lk_valid  = valid_q[idx_f];
    lk_tag    = tag_q[idx_f];
    lk_target = target_q[idx_f];
    lk_ctrs   = ctrs_q[idx_f];
`ifdef TAGGED_BTB_FWD_EN
    if (reset_n_i && upd_active && (idx_f == idx_e) && (tag_f == tag_e)) begin
      lk_valid  = nxt_valid;
      lk_tag    = nxt_tag;
      lk_target = nxt_target;
      lk_ctrs   = nxt_ctrs;
    end
`endif
    hit_f_o            = lk_valid && (lk_tag == tag_f);
    pc_src_pred_f_o    = hit_f_o && lk_ctrs[hist_f_i][CTR_W-1];
    pred_pc_target_f_o = hit_f_o ? lk_target : '0;
  end

endmodule

// File: tb/tb_tagged_branch_buffer.sv
// Directed bench for tagged_branch_buffer with a per-cycle reference model.
// Define TAGGED_BTB_FWD_EN for both bench and RTL to check the bypass build.
`timescale 1ns/1ps
module tb_tagged_branch_buffer;

  localparam int ENTRIES = 256;
  localparam int TAG_W   = 8;
  localparam int HIST_W  = 2;
  localparam int CTR_W   = 2;
  localparam int NCTR    = 1 << HIST_W;
  localparam int M_WNT   = (1 << (CTR_W - 1)) - 1;
  localparam int M_WT    = 1 << (CTR_W - 1);
  localparam int M_MAX   = (1 << CTR_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              flush = 1'b0;
  logic [31:0]       pc_f = 32'h0;
  logic [HIST_W-1:0] hist_f = '0;
  logic [31:0]       pc_e = 32'h0;
  logic [HIST_W-1:0] hist_e = '0;
  logic [1:0]        op = 2'b00;
  logic              taken = 1'b0;
  logic              tmatch = 1'b0;
  logic [31:0]       tgt_e = 32'h0;
  logic              hit, pred;
  logic [31:0]       ptgt;

  int n_cmp = 0;
  int n_bad = 0;

  tagged_branch_buffer #(
    .ENTRIES (ENTRIES),
    .TAG_W   (TAG_W),
    .HIST_W  (HIST_W),
    .CTR_W   (CTR_W)
  ) dut (
    .clk_i              (clk),
    .reset_n_i          (rst_n),
    .flush_i            (flush),
    .pc_f_i             (pc_f),
    .hist_f_i           (hist_f),
    .pc_e_i             (pc_e),
    .hist_e_i           (hist_e),
    .branch_op_e_i      (op),
    .pc_src_res_e_i     (taken),
    .target_match_i     (tmatch),
    .pc_target_e_i      (tgt_e),
    .hit_f_o            (hit),
    .pc_src_pred_f_o    (pred),
    .pred_pc_target_f_o (ptgt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (plain integer arithmetic) -------------
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  int unsigned m_target [ENTRIES];
  int          m_ctr    [ENTRIES][NCTR];

  function automatic int unsigned f_idx(input logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned f_tag(input logic [31:0] pc);
    return (pc / (4 * ENTRIES)) % (1 << TAG_W);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = 0;
      m_target[i] = 0;
      for (int j = 0; j < NCTR; j++) m_ctr[i][j] = M_WNT;
    end
  endtask

  int unsigned e_ix, e_tg, f_ix, f_tg;
  bit          e_train;
  int          e_new_ctr [NCTR];
  int unsigned e_new_tgt;
  bit          x_hit, x_pred;
  int unsigned x_tgt;

  // What the addressed entry becomes if this cycle's update is applied.
  always_comb begin
    e_ix    = f_idx(pc_e);
    e_tg    = f_tag(pc_e);
    e_train = m_valid[e_ix] && (m_tag[e_ix] == e_tg) && tmatch;
    e_new_tgt = e_train ? m_target[e_ix] : tgt_e;
    for (int j = 0; j < NCTR; j++) begin
      if (e_train) begin
        if (j != int'(hist_e))  e_new_ctr[j] = m_ctr[e_ix][j];
        else if (taken)         e_new_ctr[j] = (m_ctr[e_ix][j] + 1 > M_MAX) ? M_MAX : m_ctr[e_ix][j] + 1;
        else                    e_new_ctr[j] = (m_ctr[e_ix][j] - 1 < 0) ? 0 : m_ctr[e_ix][j] - 1;
      end else begin
        e_new_ctr[j] = (j == int'(hist_e) && taken) ? M_WT : M_WNT;
      end
    end
  end

  // Expected fetch outputs from the current model state and inputs.
  always_comb begin
    f_ix   = f_idx(pc_f);
    f_tg   = f_tag(pc_f);
    x_hit  = m_valid[f_ix] && (m_tag[f_ix] == f_tg);
    x_tgt  = x_hit ? m_target[f_ix] : 0;
    x_pred = x_hit && (m_ctr[f_ix][hist_f] >= M_WT);
`ifdef TAGGED_BTB_FWD_EN
    if (rst_n && !flush && op != 2'b00 && f_ix == e_ix && f_tg == e_tg) begin
      x_hit  = 1'b1;
      x_tgt  = e_new_tgt;
      x_pred = (e_new_ctr[hist_f] >= M_WT);
    end
`endif
  end

  // Model state update on the clock edge / asynchronous reset.
  initial begin
    m_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_clear();
      else if (flush) begin
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      end else if (op != 2'b00) begin
        m_target[e_ix] = e_new_tgt;
        for (int j = 0; j < NCTR; j++) m_ctr[e_ix][j] = e_new_ctr[j];
        m_valid[e_ix] = 1'b1;
        m_tag[e_ix]   = e_tg;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      n_cmp++;
      if (hit !== x_hit || pred !== x_pred || ptgt !== 32'(x_tgt)) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t pc_f=%h hist_f=%0d: got hit=%b pred=%b tgt=%h, expected hit=%b pred=%b tgt=%h",
                 $time, pc_f, hist_f, hit, pred, ptgt, x_hit, x_pred, x_tgt);
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lk(input logic [31:0] pc, input logic [HIST_W-1:0] h);
    pc_f   = pc;
    hist_f = h;
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [HIST_W-1:0] h,
                     input logic tk, input logic tm, input logic [31:0] tg);
    op     = 2'b01;
    pc_e   = pc;
    hist_e = h;
    taken  = tk;
    tmatch = tm;
    tgt_e  = tg;
  endtask

  task automatic idle();
    op = 2'b00;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pc_f = 32'h100;
    #1;
    chk("rst_hit",  32'(hit),  32'd0);
    chk("rst_pred", 32'(pred), 32'd0);
    chk("rst_tgt",  ptgt,      32'h0);
    rst_n = 1'b1;
    cyc();

    // Empty table after reset release
    lk(32'h100, 2'd2);
    chk("empty_hit", 32'(hit), 32'd0);
    chk("empty_tgt", ptgt, 32'h0);

    // Allocate taken on hist 2
    upd(32'h100, 2'd2, 1'b1, 1'b0, 32'h2000);
    cyc(); idle();
    lk(32'h100, 2'd2);
    chk("alloc_hit",  32'(hit),  32'd1);
    chk("alloc_pred", 32'(pred), 32'd1);
    chk("alloc_tgt",  ptgt,      32'h2000);
    lk(32'h100, 2'd1);
    chk("alloc_other_hist_pred", 32'(pred), 32'd0);

    // Train taken three times; a differing resolved target must not be stored
    upd(32'h100, 2'd2, 1'b1, 1'b1, 32'h9990);
    repeat (3) cyc();
    idle();
    lk(32'h100, 2'd2);
    chk("train_sat_pred", 32'(pred), 32'd1);
    chk("train_keep_tgt", ptgt, 32'h2000);
    upd(32'h100, 2'd2, 1'b0, 1'b1, 32'h2000);   // 3 -> 2
    cyc(); idle(); lk(32'h100, 2'd2);
    chk("nt1_pred", 32'(pred), 32'd1);
    upd(32'h100, 2'd2, 1'b0, 1'b1, 32'h2000);   // 2 -> 1
    cyc(); idle(); lk(32'h100, 2'd2);
    chk("nt2_pred", 32'(pred), 32'd0);
    upd(32'h100, 2'd2, 1'b0, 1'b1, 32'h2000);   // 1 -> 0, then held at 0
    repeat (2) cyc();
    upd(32'h100, 2'd2, 1'b1, 1'b1, 32'h2000);   // 0 -> 1 (a wrap would give 3)
    cyc(); idle(); lk(32'h100, 2'd2);
    chk("sat_low_pred", 32'(pred), 32'd0);
    upd(32'h100, 2'd2, 1'b1, 1'b1, 32'h2000);   // 1 -> 2
    cyc(); idle(); lk(32'h100, 2'd2);
    chk("recover_pred", 32'(pred), 32'd1);

    // Retarget: hit with wrong target re-initialises all counters
    upd(32'h100, 2'd1, 1'b0, 1'b0, 32'h2400);
    cyc(); idle(); lk(32'h100, 2'd2);
    chk("retgt_tgt",  ptgt, 32'h2400);
    chk("retgt_pred", 32'(pred), 32'd0);

    // Alias: tag bits are pc[17:10], so 0x4100 shares index 0x40 with 0x100
    lk(32'h4100, 2'd0);
    chk("alias_miss", 32'(hit), 32'd0);
    upd(32'h4100, 2'd0, 1'b1, 1'b1, 32'h3000);
    cyc(); idle();
    lk(32'h100, 2'd2);
    chk("alias_evicted", 32'(hit), 32'd0);
    lk(32'h4100, 2'd0);
    chk("alias_hit", 32'(hit), 32'd1);
    chk("alias_tgt", ptgt, 32'h3000);

    // Flush with a concurrent update: everything misses, update dropped
    upd(32'h800, 2'd0, 1'b1, 1'b0, 32'h6000);
    flush = 1'b1;
    cyc();
    flush = 1'b0; idle();
    lk(32'h4100, 2'd0);
    chk("flush_miss", 32'(hit), 32'd0);
    lk(32'h800, 2'd0);
    chk("flush_drop_upd", 32'(hit), 32'd0);

    // Highest index
    upd(32'h3FC, 2'd3, 1'b1, 1'b0, 32'h7000);
    cyc(); idle(); lk(32'h3FC, 2'd3);
    chk("top_idx_hit",  32'(hit),  32'd1);
    chk("top_idx_pred", 32'(pred), 32'd1);
    chk("top_idx_tgt",  ptgt,      32'h7000);

    // Mid-run reset between edges, with an update pending
    upd(32'h300, 2'd0, 1'b1, 1'b0, 32'h8000);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_hit", 32'(hit), 32'd0);
    cyc();
    rst_n = 1'b1; idle();
    cyc();
    lk(32'h300, 2'd0);
    chk("rst_lost_upd", 32'(hit), 32'd0);
    lk(32'h3FC, 2'd3);
    chk("rst_cleared", 32'(hit), 32'd0);

    // Same-cycle fetch and allocate
    upd(32'h200, 2'd0, 1'b1, 1'b0, 32'h5000);
    lk(32'h200, 2'd0);
`ifdef TAGGED_BTB_FWD_EN
    chk("same_cyc_hit", 32'(hit), 32'd1);
    chk("same_cyc_tgt", ptgt, 32'h5000);
`else
    chk("same_cyc_hit", 32'(hit), 32'd0);
    chk("same_cyc_tgt", ptgt, 32'h0);
`endif
    cyc(); idle(); lk(32'h200, 2'd0);
    chk("after_same_cyc_hit", 32'(hit), 32'd1);
    chk("after_same_cyc_tgt", ptgt, 32'h5000);

    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
